// File: rtl/redirect_fetch_if.sv
// redirect_fetch_if: fetch-control inputs and PC/status outputs of redirect_fetch
interface redirect_fetch_if;
    logic        pcen;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        ifid_flush;
    logic        halted;
    logic        misalign;
    logic [15:0] flushsum;
    logic [15:0] stallsum;
    modport master (output pcen, redirect, redirect_pc, halt,
                    input pc, pc_plus4, ifid_flush, halted, misalign, flushsum, stallsum);
    modport slave (input pcen, redirect, redirect_pc, halt,
                   output pc, pc_plus4, ifid_flush, halted, misalign, flushsum, stallsum);
endinterface

// File: rtl/redirect_fetch.sv
// redirect_fetch: fetch PC register with redirect/flush sequencing, terminal halt and event counters
module redirect_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h00000000,
    parameter int          FLUSH_CYCLES = 1
) (
    input logic             clk,
    input logic             rst,
    redirect_fetch_if.slave bus
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;
    logic [1:0]  state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [31:0] pc_nx;
    logic        live, accept, stall;
    assign live         = state != HALT;
    assign accept       = live & bus.redirect & bus.pcen & ~bus.halt;
    assign stall        = live & ~bus.pcen;
    assign bus.pc_plus4 = bus.pc + 32'd4;
    // next state/pc/counter: halt beats redirect, redirect beats sequential advance
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = bus.pc;
        if (live && bus.halt) begin
            state_nx = HALT;
        end else if (accept) begin
            state_nx = FLUSH;
            cnt_nx   = 3'(FLUSH_CYCLES);
            pc_nx    = {bus.redirect_pc[31:2], 2'b00};
        end else if (live && bus.pcen) begin
            pc_nx = bus.pc_plus4;
            if (state == FLUSH) begin
                cnt_nx   = cnt - 3'd1;
                state_nx = (cnt == 3'd1) ? RUN : FLUSH;
            end
        end
    end
    // state, outputs and saturating counters; everything frozen once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= RUN;
            cnt            <= 3'd0;
            bus.pc         <= RESET_PC;
            bus.ifid_flush <= 1'b0;
            bus.halted     <= 1'b0;
            bus.misalign   <= 1'b0;
            bus.flushsum   <= 16'd0;
            bus.stallsum   <= 16'd0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            bus.pc         <= pc_nx;
            bus.ifid_flush <= state_nx == FLUSH;
            bus.halted     <= state_nx == HALT;
            if (accept && bus.redirect_pc[1:0] != 2'b00) bus.misalign <= 1'b1;
            if (accept && bus.flushsum != 16'hFFFF) bus.flushsum <= bus.flushsum + 16'd1;
            if (stall && bus.stallsum != 16'hFFFF) bus.stallsum <= bus.stallsum + 16'd1;
        end
    end
endmodule

// File: tb/tb_redirect_fetch.sv
// tb_redirect_fetch: directed and random checks of two redirect_fetch configurations against a reference model
module tb_redirect_fetch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    redirect_fetch_if b0 ();
    redirect_fetch_if b1 ();
    redirect_fetch #(.RESET_PC(32'h00000000), .FLUSH_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    redirect_fetch #(.RESET_PC(32'h00001000), .FLUSH_CYCLES(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // reference model: remaining flush advances, halted flag, plain counters
    int          fc[2] = '{1, 2};
    logic [31:0] rp[2] = '{32'h0, 32'h1000};
    logic [31:0] m_pc[2];
    int          m_left[2], m_fs[2], m_ss[2];
    bit          m_h[2], m_mis[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = rp[i]; m_left[i] = 0; m_fs[i] = 0; m_ss[i] = 0; m_h[i] = 0; m_mis[i] = 0;
        end
    endfunction

    function automatic void m_step(logic p, logic r, logic [31:0] a, logic h);
        for (int i = 0; i < 2; i++) begin
            if (!m_h[i]) begin
                if (!p && m_ss[i] < 65535) m_ss[i]++;
                if (h) m_h[i] = 1;
                else if (p && r) begin
                    m_pc[i]   = {a[31:2], 2'b00};
                    m_left[i] = fc[i];
                    if (m_fs[i] < 65535) m_fs[i]++;
                    if (a[1:0] != 2'b00) m_mis[i] = 1;
                end else if (p) begin
                    m_pc[i] = m_pc[i] + 32'd4;
                    if (m_left[i] > 0) m_left[i]--;
                end
            end
        end
    endfunction

    task automatic check_one(input int i, input logic [31:0] pc, input logic [31:0] pp4, input logic fl,
                             input logic hl, input logic mis, input logic [15:0] fs, input logic [15:0] ss);
        string s;
        s = $sformatf("dut%0d", i);
        chk({s, ".pc"}, pc, m_pc[i]);
        chk({s, ".pc_plus4"}, pp4, m_pc[i] + 32'd4);
        chk({s, ".ifid_flush"}, 32'(fl), 32'(!m_h[i] && m_left[i] > 0));
        chk({s, ".halted"}, 32'(hl), 32'(m_h[i]));
        chk({s, ".misalign"}, 32'(mis), 32'(m_mis[i]));
        chk({s, ".flushsum"}, 32'(fs), 32'(m_fs[i]));
        chk({s, ".stallsum"}, 32'(ss), 32'(m_ss[i]));
    endtask

    task automatic check_all();
        check_one(0, b0.pc, b0.pc_plus4, b0.ifid_flush, b0.halted, b0.misalign, b0.flushsum, b0.stallsum);
        check_one(1, b1.pc, b1.pc_plus4, b1.ifid_flush, b1.halted, b1.misalign, b1.flushsum, b1.stallsum);
    endtask

    task automatic cyc(input logic p, input logic r, input logic [31:0] a, input logic h, input bit do_chk = 1);
        b0.pcen = p; b0.redirect = r; b0.redirect_pc = a; b0.halt = h;
        b1.pcen = p; b1.redirect = r; b1.redirect_pc = a; b1.halt = h;
        @(posedge clk);
        m_step(p, r, a, h);
        #1;
        if (do_chk) check_all();
    endtask

    // async reset: checked before any clock edge, released one edge later
    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        b0.pcen = 0; b0.redirect = 0; b0.redirect_pc = 0; b0.halt = 0;
        b1.pcen = 0; b1.redirect = 0; b1.redirect_pc = 0; b1.halt = 0;
        #2;
        do_reset();
        chk("reset_pc0", b0.pc, 32'h0);
        chk("reset_pc1", b1.pc, 32'h1000);
        // sequential fetch and a single-cycle flush
        cyc(1, 0, 0, 0);
        chk("first_adv", b0.pc, 32'h4);
        cyc(1, 0, 0, 0);
        chk("at8", b0.pc, 32'h8);
        cyc(1, 1, 32'h40, 0);
        chk("redir_pc", b0.pc, 32'h40);
        chk("redir_flush", 32'(b0.ifid_flush), 32'h1);
        cyc(1, 0, 0, 0);
        chk("post_flush_pc", b0.pc, 32'h44);
        chk("post_flush", 32'(b0.ifid_flush), 32'h0);
        chk("flushsum1", 32'(b0.flushsum), 32'h1);
        // redirect held off by stalls
        do_reset();
        cyc(0, 1, 32'h80, 0);
        cyc(0, 1, 32'h80, 0);
        chk("stall_hold", b0.pc, 32'h0);
        chk("stallsum2", 32'(b0.stallsum), 32'h2);
        chk("stall_nofs", 32'(b0.flushsum), 32'h0);
        cyc(1, 1, 32'h80, 0);
        chk("stall_take", b0.pc, 32'h80);
        chk("stall_fs", 32'(b0.flushsum), 32'h1);
        // back-to-back redirects with two flush cycles
        do_reset();
        cyc(1, 1, 32'h100, 0);
        chk("b2b_f1", 32'(b1.ifid_flush), 32'h1);
        cyc(1, 1, 32'h200, 0);
        chk("b2b_pc", b1.pc, 32'h200);
        chk("b2b_f2", 32'(b1.ifid_flush), 32'h1);
        cyc(1, 0, 0, 0);
        chk("b2b_f3", 32'(b1.ifid_flush), 32'h1);
        cyc(1, 0, 0, 0);
        chk("b2b_f4", 32'(b1.ifid_flush), 32'h0);
        chk("b2b_fs", 32'(b1.flushsum), 32'h2);
        // halt beats redirect and is terminal
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
        chk("pre_halt", b0.pc, 32'h20);
        cyc(1, 1, 32'h40, 1);
        chk("halted", 32'(b0.halted), 32'h1);
        chk("halt_pc", b0.pc, 32'h20);
        for (int i = 0; i < 4; i++) cyc(i[0], 1, 32'h300, i[1]);
        chk("halt_frozen", b0.pc, 32'h20);
        chk("halt_fs", 32'(b0.flushsum), 32'h0);
        do_reset();
        chk("halt_rst_h", 32'(b0.halted), 32'h0);
        // misalign stickiness and pc wrap
        cyc(1, 1, 32'h43, 0);
        chk("mis_pc", b0.pc, 32'h40);
        chk("mis_set", 32'(b0.misalign), 32'h1);
        cyc(1, 1, 32'h80, 0);
        chk("mis_sticky", 32'(b0.misalign), 32'h1);
        cyc(1, 1, 32'hFFFFFFFE, 0);
        chk("wrap_p4", b0.pc_plus4, 32'h0);
        cyc(1, 0, 0, 0);
        chk("wrap_pc", b0.pc, 32'h0);
        do_reset();
        chk("mis_clr", 32'(b0.misalign), 32'h0);
        // stallsum saturation
        for (int i = 0; i < 65540; i++) cyc(0, 0, 0, 0, 0);
        check_all();
        chk("ss_sat", 32'(b0.stallsum), 32'hFFFF);
        // random traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) do_reset();
            else cyc(($urandom_range(3) != 0), ($urandom_range(9) < 3),
                     ($urandom_range(3) == 0) ? 32'($urandom) : {20'h0, 12'($urandom)},
                     ($urandom_range(99) < 2));
            if (m_h[0] && $urandom_range(19) == 0) do_reset();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
